// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the OTTER pipeline control blocks.
package otter_pipe_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_sched_fwd_unit.sv
// Forwarding select for one E-stage operand; the M stage wins over W.
module fwd_unit
  import otter_pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output fwd_sel_t         fwd_sel_c
);

  always_comb begin
    fwd_sel_c = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      fwd_sel_c = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      fwd_sel_c = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// OTTER 5-stage hazard scheduler: stalls, flushes, forwarding and memory-wait FSM.
// Optional stall-cycle performance counter is built when HAZARD_PERF_EN is defined.
module hazard_sched
  import otter_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemTimeoutErr,
  output logic [31:0]      StallCycles
);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             lw_stall;
  logic             forced_release;
  logic             stall_all;
  fwd_sel_t         fwd_a_c, fwd_b_c;

  fwd_unit u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel_c   (fwd_a_c)
  );

  fwd_unit u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel_c   (fwd_b_c)
  );

  assign lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // Wait FSM: an ack or the timeout releases the freeze in the same cycle.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    forced_release = 1'b0;
    stall_all      = 1'b0;
    case (state_q)
      RUN: begin
        if (MemReqM && !MemAckM) begin
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
          cnt_d     = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemAckM) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          forced_release = 1'b1;
          state_d        = RUN;
          cnt_d          = '0;
        end else begin
          stall_all = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    if (forced_release) begin
      err_d = 1'b1;
    end
  end

  // Pipeline controls; a freeze defers any pending redirect flush.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (RST_N) begin
      ForwardAE = fwd_a_c;
      ForwardBE = fwd_b_c;
      if (stall_all) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign MemTimeoutErr = err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;
`else
  assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched (MEM_TIMEOUT=4); counter checks follow HAZARD_PERF_EN.
module tb_hazard_sched;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK, RST_N;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM;
  logic [1:0]  ResultSrcE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeoutErr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCycles;

  int checks = 0;
  int errors = 0;

  hazard_sched #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemTimeoutErr(MemTimeoutErr), .StallCycles(StallCycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02b expected %02b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stall/flush vector check: {StallF,StallD,StallE,StallM,FlushD,FlushE}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {StallF, StallD, StallE, StallM, FlushD, FlushE};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed SF,SD,SE,SM,FD,FE=%06b expected %06b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic quiet();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;
    PCSrcE = 1'b0; MemReqM = 1'b0; MemAckM = 1'b0;
  endtask

  initial begin
    // Reset with live hazards on the inputs: outputs must stay forced
    RST_N = 1'b0;
    quiet();
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; MemReqM = 1'b1;
    #3;
    chk_ctl("reset_ctl", 6'b0000_11);
    chk2("reset_fwdA", ForwardAE, 2'b00);
    chk1("reset_err", MemTimeoutErr, 1'b0);
    chk32("reset_perf", StallCycles, 32'd0);

    cyc(); quiet(); RST_N = 1'b1; #1;
    chk_ctl("idle_ctl", 6'b0000_00);

    // Forwarding
    cyc();
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd5; #1;
    chk2("fwdA_M_prio", ForwardAE, 2'b10);
    chk2("fwdB_M_prio", ForwardBE, 2'b10);
    RdM = 5'd0; #1;
    chk2("fwdA_W", ForwardAE, 2'b01);
    chk2("fwdB_W", ForwardBE, 2'b01);
    RegWriteW = 1'b0; RegWriteM = 1'b0; RdM = 5'd5; #1;
    chk2("fwdB_none", ForwardBE, 2'b00);
    RdW = 5'd0; RegWriteW = 1'b1; Rs1E = 5'd0; #1;
    chk2("fwdA_x0", ForwardAE, 2'b00);
    RegWriteW = 1'b0; RegWriteM = 1'b1; RdM = 5'd9; Rs1E = 5'd9; Rs2E = 5'd3; #1;
    chk2("fwdA_M_only", ForwardAE, 2'b10);
    chk2("fwdB_M_miss", ForwardBE, 2'b00);

    // Load-use
    cyc(); quiet(); ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; #1;
    chk_ctl("lw_stall", 6'b1100_01);
    cyc(); RdE = 5'd0; #1;
    chk_ctl("lw_rd0", 6'b0000_00);
    cyc(); quiet(); ResultSrcE = 2'b10; RdE = 5'd7; Rs1D = 5'd7; #1;
    chk_ctl("nonload_match", 6'b0000_00);

    // Redirect only
    cyc(); quiet(); PCSrcE = 1'b1; #1;
    chk_ctl("branch", 6'b0000_11);

    // Memory wait, ack on the 4th cycle
    cyc(); quiet(); MemReqM = 1'b1; #1;
    chk_ctl("mem_c1", 6'b1111_00);
    cyc(); #1; chk_ctl("mem_c2", 6'b1111_00);
    cyc(); #1; chk_ctl("mem_c3", 6'b1111_00);
    cyc(); MemAckM = 1'b1; #1;
    chk_ctl("mem_ack", 6'b0000_00);
    cyc(); quiet(); #1;
    chk_ctl("mem_back_run", 6'b0000_00);
    chk1("mem_no_err", MemTimeoutErr, 1'b0);
    cyc(); MemReqM = 1'b1; MemAckM = 1'b1; #1;
    chk_ctl("mem_same_cycle_ack", 6'b0000_00);
    cyc(); quiet(); #1;
    chk_ctl("mem_same_cycle_run", 6'b0000_00);

    // Memory wait with a pending redirect
    cyc(); MemReqM = 1'b1; PCSrcE = 1'b1; #1;
    chk_ctl("memb_c1", 6'b1111_00);
    cyc(); #1; chk_ctl("memb_c2", 6'b1111_00);
    cyc(); #1; chk_ctl("memb_c3", 6'b1111_00);
    cyc(); MemAckM = 1'b1; #1;
    chk_ctl("memb_ack_flush", 6'b0000_11);

    // Timeout
    cyc(); quiet(); MemReqM = 1'b1; #1;
    chk_ctl("to_c1", 6'b1111_00);
    cyc(); #1; chk_ctl("to_c2", 6'b1111_00);
    cyc(); #1; chk_ctl("to_c3", 6'b1111_00);
    chk1("to_err_pre", MemTimeoutErr, 1'b0);
    cyc(); #1; chk_ctl("to_release", 6'b0000_00);
    chk1("to_err_not_yet", MemTimeoutErr, 1'b0);
    cyc(); quiet(); #1;
    chk1("to_err_set", MemTimeoutErr, 1'b1);
    chk_ctl("to_run", 6'b0000_00);
    cyc(); #1;
    chk1("to_err_sticky", MemTimeoutErr, 1'b1);

    // Load-use together with redirect
    cyc(); ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1; #1;
    chk_ctl("lw_and_branch", 6'b1100_11);

    // Reset pulse clears the sticky error and the counter
    cyc(); quiet(); RST_N = 1'b0; #1;
    chk1("rst_err_clr", MemTimeoutErr, 1'b0);
    chk32("rst_perf_clr", StallCycles, 32'd0);
    cyc(); RST_N = 1'b1; #1;
    chk32("perf_start", StallCycles, 32'd0);

    // 2-cycle load-use then 3-cycle memory wait
    cyc(); ResultSrcE = 2'b01; RdE = 5'd4; Rs1D = 5'd4; #1;
    chk1("perf_lw1", StallF, 1'b1);
    cyc(); #1; chk1("perf_lw2", StallF, 1'b1);
    cyc(); quiet(); MemReqM = 1'b1; #1;
    chk1("perf_m1", StallF, 1'b1);
    cyc(); #1;
    cyc(); #1;
    cyc(); MemAckM = 1'b1; #1;
    chk1("perf_ack", StallF, 1'b0);
    cyc(); quiet(); #1;
    chk32("perf_five", StallCycles, PERF ? 32'd5 : 32'd0);

    // Reset in the middle of a wait
    cyc(); MemReqM = 1'b1; #1;
    chk_ctl("midrst_c1", 6'b1111_00);
    cyc(); #1;
    chk32("perf_six", StallCycles, PERF ? 32'd6 : 32'd0);
    RST_N = 1'b0; #1;
    chk_ctl("midrst_forced", 6'b0000_11);
    chk32("midrst_perf", StallCycles, 32'd0);
    cyc(); quiet(); RST_N = 1'b1; #1;
    chk_ctl("midrst_run", 6'b0000_00);
    cyc(); #1;
    chk_ctl("midrst_run2", 6'b0000_00);
    chk32("midrst_perf_hold", StallCycles, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
